alarm_zone_controller: RTL and testbench
========================================

ALARM_ZONE_CONTROLLER -- requirements
Module: alarm_zone_controller

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of distance-sensor zones, 1..16.
REQ-002 SHALL have parameter DIST_W, default 8: distance width per zone, in bits.
REQ-003 SHALL have parameter THRESH, default 50: intrusion when distance < THRESH.
REQ-004 SHALL have parameter CONFIRM_CYC, default 16: consecutive cycles needed to confirm a detection or a clear, >=1.
REQ-005 SHALL have parameter EXIT_CYC, default 1024: exit-delay length in cycles, >=1.
REQ-006 SHALL have port CLK  input  1: trigger clock for all logic.
REQ-007 SHALL have port RST  input  1: system reset, asynchronous, active-high.
REQ-008 SHALL have port Arm  input  1: level arm request; 1 = armed, 0 = disarm.
REQ-009 SHALL have port Zone_Mask  input  N_CH: 1 = zone enabled.
REQ-010 SHALL have port Distance  input  N_CH*DIST_W: packed zone distances, zone 0 in the LSBs.
REQ-011 SHALL have port Sound_Data  output  1: alarm tone square wave.
REQ-012 SHALL have port Sound_Trig  output  1: one-cycle alarm trigger impulse.
REQ-013 SHALL have port Alarm_Zones  output  N_CH: zones that contributed to the current alarm.
REQ-014 SHALL have port State  output  2: FSM state code.

Function
REQ-015 SHALL implement states DISARMED=0, EXIT=1, ARMED=2, ALARM=3.
REQ-016 SHALL define detect = OR over zones i of (Zone_Mask[i] and Distance_i < THRESH); distance == THRESH is not a detection.
REQ-017 SHALL move DISARMED->EXIT when Arm=1, clearing the exit counter.
REQ-018 SHALL hold EXIT for exactly EXIT_CYC cycles, then enter ARMED; detections are ignored during EXIT.
REQ-019 SHALL in ARMED increment the confirm counter while detect=1 and zero it when detect=0; entry to ALARM occurs on the edge at which the count reaches CONFIRM_CYC.
REQ-020 SHALL assert Sound_Trig for exactly the first cycle in which State=ALARM, and never otherwise.
REQ-021 SHALL in ALARM OR each detecting zone into Alarm_Zones every cycle; zones are never removed while in ALARM.
REQ-022 SHALL in ALARM toggle Sound_Data with half-period = min_dist+1 cycles, where min_dist is the registered minimum Distance over enabled zones; the new half-period takes effect at the next reload.
REQ-023 SHALL hold Sound_Data at 0 in every state other than ALARM.
REQ-024 SHALL on Arm=0 in any state enter DISARMED at the next edge, clearing Alarm_Zones, all counters and Sound_Data; this has priority over every other transition.
REQ-025 SHALL never detect when Zone_Mask is all zero; min_dist SHALL then be all ones.

Reset
REQ-026 SHALL on RST=1 force State=DISARMED, Sound_Data=0, Sound_Trig=0, Alarm_Zones=0 and all counters to 0, immediately and without waiting for CLK.
REQ-027 SHALL treat reset in mid-alarm identically; after release, a new arm starts from the full exit delay.

Configuration
REQ-028 SHALL with ALARM_LATCH_EN defined hold ALARM until Arm=0 or RST.
REQ-029 SHALL without ALARM_LATCH_EN return ALARM->ARMED after CONFIRM_CYC consecutive cycles with detect=0, clearing Alarm_Zones on that edge.

Structure
REQ-030 SHALL place the state encoding, its 2-bit width constant and the default THRESH/CONFIRM_CYC/EXIT_CYC values in shared package alarm_pkg.
REQ-031 SHALL implement the tone divider as sub-module alarm_tone_gen, with inputs CLK, RST, enable and half-period and output Sound_Data.

Verification
Bench parameters for all scenarios: N_CH=4, DIST_W=8, THRESH=50, CONFIRM_CYC=4, EXIT_CYC=8.
REQ-032 SHALL cover: Zone_Mask=1111, zone 2=20, others=200, Arm=1 -> State=1 for 8 cycles, then 2, then 3 after 4 cycles; one Sound_Trig pulse; Alarm_Zones=0100.
REQ-033 SHALL cover: in ARMED, zone 1=30 for 3 cycles then 200 -> stays ARMED; Sound_Trig never asserted.
REQ-034 SHALL cover: ALARM with zone 0=9 as the minimum -> Sound_Data toggles every 10 cycles; zone 0 changed to 19 -> toggles every 20 cycles after the next reload.
REQ-035 SHALL cover: zone 3=50 with mask 1111, and zone 0=0 with mask 1110 -> no alarm for 100 cycles.
REQ-036 SHALL cover: in ALARM, all zones set to 200 -> without ALARM_LATCH_EN, ARMED after 4 cycles and Alarm_Zones=0; with ALARM_LATCH_EN, stays ALARM until Arm=0, then DISARMED next edge.
REQ-037 SHALL cover: RST pulsed between clock edges during ALARM -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing constants for the alarm zone controller.
package alarm_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_DISARMED = 2'd0;
  localparam logic [STATE_W-1:0] ST_EXIT     = 2'd1;
  localparam logic [STATE_W-1:0] ST_ARMED    = 2'd2;
  localparam logic [STATE_W-1:0] ST_ALARM    = 2'd3;

  localparam int THRESH_DEF      = 50;
  localparam int CONFIRM_CYC_DEF = 16;
  localparam int EXIT_CYC_DEF    = 1024;

endpackage

// File: rtl/alarm_tone_gen.sv
// Alarm tone divider: square wave whose half-period is reloaded at every toggle.
module alarm_tone_gen #(
  parameter int PER_W = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [PER_W-1:0] half_period,
  output logic             Sound_Data
);

  logic [PER_W-1:0] cnt_r;
  logic [PER_W-1:0] per_r;
  logic             tone_r;

  // Idle preloads the counter to all ones so the first enabled edge wraps to zero
  // and the first half-period is as long as every later one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r  <= {PER_W{1'b0}};
      per_r  <= PER_W'(1);
      tone_r <= 1'b0;
    end else if (!enable) begin
      cnt_r  <= {PER_W{1'b1}};
      per_r  <= half_period;
      tone_r <= 1'b0;
    end else if (cnt_r == per_r - PER_W'(1)) begin
      cnt_r  <= {PER_W{1'b0}};
      per_r  <= half_period;
      tone_r <= ~tone_r;
    end else begin
      cnt_r  <= cnt_r + PER_W'(1);
    end
  end

  assign Sound_Data = tone_r;

endmodule

// File: rtl/alarm_zone_controller.sv
// Multi-zone distance intrusion alarm FSM with exit delay, confirmation and tone output.
// Define ALARM_LATCH_EN to hold ALARM until disarm instead of auto-clearing.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIST_W      = 8,
  parameter int THRESH      = THRESH_DEF,
  parameter int CONFIRM_CYC = CONFIRM_CYC_DEF,
  parameter int EXIT_CYC    = EXIT_CYC_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Arm,
  input  logic [N_CH-1:0]          Zone_Mask,
  input  logic [N_CH*DIST_W-1:0]   Distance,
  output logic                     Sound_Data,
  output logic                     Sound_Trig,
  output logic [N_CH-1:0]          Alarm_Zones,
  output logic [STATE_W-1:0]       State
);

  localparam int DW1    = DIST_W + 1;
  localparam int EXIT_W = $clog2(EXIT_CYC + 1);
  localparam int CONF_W = $clog2(CONFIRM_CYC + 1);

  localparam logic [DW1-1:0]    THRESH_V  = DW1'(THRESH);
  localparam logic [EXIT_W-1:0] EXIT_LAST = EXIT_W'(EXIT_CYC - 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYC - 1);

  logic [STATE_W-1:0] state_r, state_nxt_s;
  logic [EXIT_W-1:0]  exit_cnt_r, exit_cnt_nxt_s;
  logic [CONF_W-1:0]  conf_cnt_r, conf_cnt_nxt_s;
  logic [N_CH-1:0]    zones_r, zones_nxt_s;
  logic [N_CH-1:0]    det_vec_s;
  logic               detect_s;
  logic [DIST_W-1:0]  min_dist_s, min_dist_r;
  logic               trig_r;
  logic [DW1-1:0]     half_period_s;
  logic               tone_en_s;

  // Per-zone detection and minimum distance over enabled zones.
  always_comb begin
    det_vec_s  = {N_CH{1'b0}};
    min_dist_s = {DIST_W{1'b1}};
    for (int i = 0; i < N_CH; i++) begin
      det_vec_s[i] = Zone_Mask[i] & ({1'b0, Distance[i*DIST_W +: DIST_W]} < THRESH_V);
      if (Zone_Mask[i] && (Distance[i*DIST_W +: DIST_W] < min_dist_s)) begin
        min_dist_s = Distance[i*DIST_W +: DIST_W];
      end else begin
        min_dist_s = min_dist_s;
      end
    end
    detect_s = |det_vec_s;
  end

  // Next-state logic; a dropped Arm overrides every other transition.
  always_comb begin
    state_nxt_s    = state_r;
    exit_cnt_nxt_s = exit_cnt_r;
    conf_cnt_nxt_s = conf_cnt_r;
    zones_nxt_s    = zones_r;
    if (!Arm) begin
      state_nxt_s    = ST_DISARMED;
      exit_cnt_nxt_s = {EXIT_W{1'b0}};
      conf_cnt_nxt_s = {CONF_W{1'b0}};
      zones_nxt_s    = {N_CH{1'b0}};
    end else begin
      case (state_r)
        ST_DISARMED: begin
          state_nxt_s    = ST_EXIT;
          exit_cnt_nxt_s = {EXIT_W{1'b0}};
          conf_cnt_nxt_s = {CONF_W{1'b0}};
          zones_nxt_s    = {N_CH{1'b0}};
        end
        ST_EXIT: begin
          if (exit_cnt_r == EXIT_LAST) begin
            state_nxt_s    = ST_ARMED;
            exit_cnt_nxt_s = {EXIT_W{1'b0}};
            conf_cnt_nxt_s = {CONF_W{1'b0}};
          end else begin
            exit_cnt_nxt_s = exit_cnt_r + EXIT_W'(1);
          end
        end
        ST_ARMED: begin
          if (!detect_s) begin
            conf_cnt_nxt_s = {CONF_W{1'b0}};
          end else if (conf_cnt_r == CONF_LAST) begin
            state_nxt_s    = ST_ALARM;
            conf_cnt_nxt_s = {CONF_W{1'b0}};
            zones_nxt_s    = det_vec_s;
          end else begin
            conf_cnt_nxt_s = conf_cnt_r + CONF_W'(1);
          end
        end
        ST_ALARM: begin
          zones_nxt_s = zones_r | det_vec_s;
`ifdef ALARM_LATCH_EN
          conf_cnt_nxt_s = {CONF_W{1'b0}};
`else
          if (detect_s) begin
            conf_cnt_nxt_s = {CONF_W{1'b0}};
          end else if (conf_cnt_r == CONF_LAST) begin
            state_nxt_s    = ST_ARMED;
            conf_cnt_nxt_s = {CONF_W{1'b0}};
            zones_nxt_s    = {N_CH{1'b0}};
          end else begin
            conf_cnt_nxt_s = conf_cnt_r + CONF_W'(1);
          end
`endif
        end
        default: begin
          state_nxt_s    = ST_DISARMED;
          exit_cnt_nxt_s = {EXIT_W{1'b0}};
          conf_cnt_nxt_s = {CONF_W{1'b0}};
          zones_nxt_s    = {N_CH{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_DISARMED;
      exit_cnt_r <= {EXIT_W{1'b0}};
      conf_cnt_r <= {CONF_W{1'b0}};
      zones_r    <= {N_CH{1'b0}};
      trig_r     <= 1'b0;
      min_dist_r <= {DIST_W{1'b1}};
    end else begin
      state_r    <= state_nxt_s;
      exit_cnt_r <= exit_cnt_nxt_s;
      conf_cnt_r <= conf_cnt_nxt_s;
      zones_r    <= zones_nxt_s;
      trig_r     <= (state_nxt_s == ST_ALARM) && (state_r != ST_ALARM);
      min_dist_r <= min_dist_s;
    end
  end

  // Enable follows the next state so the tone starts and stops on the same edge as ALARM.
  assign tone_en_s     = (state_nxt_s == ST_ALARM);
  assign half_period_s = {1'b0, min_dist_r} + DW1'(1);

  alarm_tone_gen #(
    .PER_W(DW1)
  ) u_tone (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (tone_en_s),
    .half_period(half_period_s),
    .Sound_Data (Sound_Data)
  );

  assign State       = state_r;
  assign Sound_Trig  = trig_r;
  assign Alarm_Zones = zones_r;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Scoreboard bench for alarm_zone_controller (N_CH=4, THRESH=50, CONFIRM_CYC=4, EXIT_CYC=8).
module tb_alarm_zone_controller;
  import alarm_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Arm;
  logic [3:0]  Zone_Mask;
  logic [31:0] Distance;
  logic        Sound_Data;
  logic        Sound_Trig;
  logic [3:0]  Alarm_Zones;
  logic [1:0]  State;

  always #5 CLK = ~CLK;

  alarm_zone_controller #(
    .N_CH(4), .DIST_W(8), .THRESH(50), .CONFIRM_CYC(4), .EXIT_CYC(8)
  ) dut (
    .CLK(CLK), .RST(RST), .Arm(Arm), .Zone_Mask(Zone_Mask), .Distance(Distance),
    .Sound_Data(Sound_Data), .Sound_Trig(Sound_Trig), .Alarm_Zones(Alarm_Zones), .State(State)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [1:0] st, input logic trig,
                            input logic [3:0] z);
    push_exp({tag, ".state"}, 0, {30'd0, st});
    push_exp({tag, ".trig"},  1, {31'd0, trig});
    push_exp({tag, ".zones"}, 2, {28'd0, z});
  endtask

  function automatic logic [31:0] dut_out(input int sel);
    case (sel)
      0:       return {30'd0, State};
      1:       return {31'd0, Sound_Trig};
      2:       return {28'd0, Alarm_Zones};
      3:       return {31'd0, Sound_Data};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, dut_out(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
    drain();
  endtask

  task automatic set_dist(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    Distance = {d3, d2, d1, d0};
  endtask

  // Cycles until Sound_Data changes; a runaway count shows up as a miscompare.
  task automatic wait_toggle(output int cnt);
    logic prev;
    prev = Sound_Data;
    cnt  = 0;
    do begin
      cyc();
      cnt++;
    end while (Sound_Data == prev && cnt < 600);
  endtask

  initial begin
    RST = 1'b1;
    Arm = 1'b0;
    Zone_Mask = 4'b0000;
    set_dist(8'd200, 8'd200, 8'd200, 8'd200);
    #1;
    expect_all("reset", ST_DISARMED, 1'b0, 4'b0000);
    push_exp("reset.sound", 3, 32'd0);
    drain();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Zone 2 intrusion through exit delay and confirmation
    Zone_Mask = 4'b1111;
    set_dist(8'd200, 8'd200, 8'd20, 8'd200);
    Arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_all($sformatf("exit%0d", i), ST_EXIT, 1'b0, 4'b0000);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      expect_all($sformatf("armed%0d", i), ST_ARMED, 1'b0, 4'b0000);
      push_exp("armed.sound", 3, 32'd0);
      cyc();
    end
    expect_all("alarm_entry", ST_ALARM, 1'b1, 4'b0100);
    cyc();
    expect_all("alarm_hold", ST_ALARM, 1'b0, 4'b0100);
    cyc();

    // Tone pitch follows the nearest enabled zone
    set_dist(8'd9, 8'd200, 8'd200, 8'd200);
    wait_toggle(n);
    for (int i = 0; i < 2; i++) begin
      wait_toggle(n);
      check_val("tone_hp10", n, 32'd10);
    end
    set_dist(8'd19, 8'd200, 8'd200, 8'd200);
    wait_toggle(n);
    for (int i = 0; i < 2; i++) begin
      wait_toggle(n);
      check_val("tone_hp20", n, 32'd20);
    end
    expect_all("zones_accum", ST_ALARM, 1'b0, 4'b0101);
    drain();

    // All zones clear
    set_dist(8'd200, 8'd200, 8'd200, 8'd200);
`ifdef ALARM_LATCH_EN
    for (int i = 0; i < 8; i++) begin
      expect_all($sformatf("latched%0d", i), ST_ALARM, 1'b0, 4'b0101);
      cyc();
    end
`else
    for (int i = 0; i < 3; i++) begin
      expect_all($sformatf("clr_wait%0d", i), ST_ALARM, 1'b0, 4'b0101);
      cyc();
    end
    expect_all("clr_armed", ST_ARMED, 1'b0, 4'b0000);
    push_exp("clr_armed.sound", 3, 32'd0);
    cyc();
`endif
    Arm = 1'b0;
    expect_all("disarm", ST_DISARMED, 1'b0, 4'b0000);
    push_exp("disarm.sound", 3, 32'd0);
    cyc();
    Arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_all($sformatf("rearm_exit%0d", i), ST_EXIT, 1'b0, 4'b0000);
      cyc();
    end
    expect_all("rearm_armed", ST_ARMED, 1'b0, 4'b0000);
    cyc();

    // Short burst below the confirmation count
    set_dist(8'd200, 8'd30, 8'd200, 8'd200);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) set_dist(8'd200, 8'd200, 8'd200, 8'd200);
      expect_all($sformatf("burst%0d", i), ST_ARMED, 1'b0, 4'b0000);
      cyc();
    end

    // Distance equal to threshold, then an intrusion on a masked zone
    set_dist(8'd200, 8'd200, 8'd200, 8'd50);
    for (int i = 0; i < 100; i++) begin
      expect_all("at_thresh", ST_ARMED, 1'b0, 4'b0000);
      cyc();
    end
    Zone_Mask = 4'b1110;
    set_dist(8'd0, 8'd200, 8'd200, 8'd200);
    for (int i = 0; i < 100; i++) begin
      expect_all("masked", ST_ARMED, 1'b0, 4'b0000);
      cyc();
    end

    // Reset pulse between edges in mid-alarm
    Zone_Mask = 4'b1111;
    set_dist(8'd200, 8'd200, 8'd20, 8'd200);
    for (int i = 0; i < 3; i++) begin
      expect_all($sformatf("f_armed%0d", i), ST_ARMED, 1'b0, 4'b0000);
      cyc();
    end
    expect_all("f_entry", ST_ALARM, 1'b1, 4'b0100);
    cyc();
    for (int i = 0; i < 25; i++) cyc();
    expect_all("f_pre_rst", ST_ALARM, 1'b0, 4'b0100);
    push_exp("f_pre_rst.sound", 3, 32'd1);
    drain();
    #2;
    RST = 1'b1;
    #1;
    expect_all("mid_rst", ST_DISARMED, 1'b0, 4'b0000);
    push_exp("mid_rst.sound", 3, 32'd0);
    drain();
    #1;
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_all($sformatf("post_rst_exit%0d", i), ST_EXIT, 1'b0, 4'b0000);
      cyc();
    end
    expect_all("post_rst_armed", ST_ARMED, 1'b0, 4'b0000);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
